// File: rtl/led_code_if.sv
// Requester/LED bundle for the blink-code scheduler.
// master: drives req/code; slave: drives ack/busy/led/led1.
interface led_code_if;
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  ack;
    logic        busy;
    logic        led;
    logic        led1;

    modport master (
        output req,
        output code,
        input  ack,
        input  busy,
        input  led,
        input  led1
    );

    modport slave (
        input  req,
        input  code,
        output ack,
        output busy,
        output led,
        output led1
    );
endinterface

// File: rtl/led_code_scheduler.sv
// Round-robin blink-code scheduler owning the two user LEDs.
// Ports: clk, rst_n (async low), bus (slave: req/code in, ack/busy/led/led1 out).
module led_code_scheduler #(
    parameter int TICK_DIV  = 1_200_000,
    parameter int ON_TICKS  = 3,
    parameter int OFF_TICKS = 3,
    parameter int GAP_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    led_code_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_ACK
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    tick_q, tick_d;
    logic [3:0]    remain_q, remain_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          led_q, led_d;

    logic [7:0]    phase_len;
    logic          tick_end;
    logic          phase_end;

    logic          gnt_vld;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;
    logic [3:0]    gnt_code;

    // Phase length in ticks for the current state.
    always_comb begin
        phase_len = 8'd1;
        unique case (state_q)
            S_ON:    phase_len = 8'(ON_TICKS);
            S_OFF:   phase_len = 8'(OFF_TICKS);
            S_GAP:   phase_len = 8'(GAP_TICKS);
            default: phase_len = 8'd1;
        endcase
    end

    assign tick_end  = (pre_q == PRE_MAX);
    assign phase_end = tick_end && (tick_q == phase_len - 8'd1);

    // Search last+1 .. last+4; the i=4 step revisits last, so a
    // requester just served only wins when nobody else is asking.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        cand    = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!gnt_vld && bus.req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_code = bus.code[{gnt_idx, 2'b00} +: 4];

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        last_d   = last_q;
        if (tick_end) begin
            pre_d  = '0;
            tick_d = tick_q + 8'd1;
        end else begin
            pre_d  = pre_q + 1'b1;
            tick_d = tick_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    last_d   = gnt_idx;
                    remain_d = gnt_code;
                    state_d  = (gnt_code == 4'd0) ? S_ACK : S_ON;
                end
            end
            S_ON: begin
                if (phase_end) begin
                    remain_d = remain_q - 4'd1;
                    state_d  = (remain_q == 4'd1) ? S_GAP : S_OFF;
                end
            end
            S_OFF: begin
                if (phase_end) begin
                    state_d = S_ON;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timing restarts on every state entry; idle keeps it parked.
        if (state_d != state_q || state_q == S_IDLE) begin
            pre_d  = '0;
            tick_d = '0;
        end

        // Outputs are registered copies of the next state.
        busy_d = (state_d != S_IDLE);
        led_d  = (state_d == S_ON);
        ack_d  = (state_d == S_ACK) ? (4'b0001 << last_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            tick_q   <= '0;
            remain_q <= '0;
            last_q   <= 2'd3;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            remain_q <= remain_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;
    assign bus.led  = led_q;
    assign bus.led1 = busy_q;

endmodule

// File: tb/tb_led_code_scheduler.sv
// Scoreboard bench for led_code_scheduler.
// Expected acks queued at drive time, checked when ack appears.
`timescale 1ns/1ps
module tb_led_code_scheduler;

    localparam int DIV = 2;
    localparam int ONT = 1;
    localparam int OFT = 1;
    localparam int GPT = 2;

    typedef struct {
        int idx;
        int code;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    exp_t sb[$];

    led_code_if bus_if ();

    led_code_scheduler #(
        .TICK_DIV  (DIV),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFT),
        .GAP_TICKS (GPT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_len(input int n);
        if (n == 0) return 1;
        return (n * ONT + (n - 1) * OFT + GPT) * DIV + 1;
    endfunction

    function automatic logic [63:0] exp_pat(input int n);
        logic [63:0] p;
        p = '0;
        if (n == 0) return p;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < ONT * DIV; c++) p = {p[62:0], 1'b1};
            if (k < n - 1)
                for (int c = 0; c < OFT * DIV; c++) p = {p[62:0], 1'b0};
        end
        for (int c = 0; c < GPT * DIV + 1; c++) p = {p[62:0], 1'b0};
        return p;
    endfunction

    // Monitor: tracks the current busy run and pops the scoreboard on ack.
    initial begin
        int          run_len;
        logic [63:0] hist;
        bit          post_ack;
        exp_t        e;
        run_len  = 0;
        hist     = '0;
        post_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_len  = 0;
                hist     = '0;
                post_ack = 1'b0;
            end else begin
                check("led1_eq_busy", 64'(bus_if.led1), 64'(bus_if.busy));
                if (post_ack) begin
                    check("idle_after_ack", 64'(bus_if.busy), 64'd0);
                    post_ack = 1'b0;
                end
                if (bus_if.busy) begin
                    run_len++;
                    hist = {hist[62:0], bus_if.led};
                end
                if (bus_if.ack != 4'd0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 64'(bus_if.ack), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("ack_id", 64'(bus_if.ack), 64'(4'b0001 << e.idx));
                        check("ack_busy", 64'(bus_if.busy), 64'd1);
                        check("busy_len", 64'(run_len), 64'(exp_len(e.code)));
                        check("led_pat", hist, exp_pat(e.code));
                    end
                    post_ack = 1'b1;
                end
                if (!bus_if.busy) begin
                    run_len = 0;
                    hist    = '0;
                end
            end
        end
    end

    task automatic push(input int idx, input int code);
        exp_t e;
        e.idx  = idx;
        e.code = code;
        sb.push_back(e);
    endtask

    // Waits (bounded) for ack[idx], then drops that requester's req.
    task automatic wait_ack(input int idx);
        int n;
        bit found;
        n     = 0;
        found = 1'b0;
        while (!found && n < 300) begin
            @(negedge clk);
            n++;
            if (bus_if.ack[idx]) found = 1'b1;
        end
        check("ack_seen", 64'(found), 64'd1);
        if (found) bus_if.req[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int n;
        bit prev;
        n_chk = 0;
        n_err = 0;

        // Reset with all requests asserted.
        rst_n       = 1'b0;
        bus_if.req  = 4'hF;
        bus_if.code = 16'h1111;
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(bus_if.ack), 64'd0);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_led", 64'(bus_if.led), 64'd0);
        check("rst_led1", 64'(bus_if.led1), 64'd0);
        bus_if.req = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single code 3; code change after grant must be ignored.
        bus_if.code = 16'h0003;
        push(0, 3);
        bus_if.req = 4'b0001;
        @(negedge clk);
        check("grant_lat", 64'(bus_if.busy & bus_if.led), 64'd1);
        bus_if.code = 16'h000F;
        wait_ack(0);
        @(negedge clk);

        // Simultaneous requests after reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.code = 16'h1111;
        for (int i = 0; i < 4; i++) push(i, 1);
        bus_if.req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_ack(i);
            if (i < 3) begin
                @(negedge clk);
                check("gap_idle", 64'(bus_if.busy), 64'd0);
                @(negedge clk);
                check("regrant", 64'(bus_if.busy), 64'd1);
            end
        end
        @(negedge clk);

        // Round-robin wrap: after 1, search 2,3,0.
        push(1, 1);
        bus_if.req = 4'b0010;
        wait_ack(1);
        @(negedge clk);
        push(0, 1);
        push(1, 1);
        bus_if.req = 4'b0011;
        wait_ack(0);
        wait_ack(1);
        @(negedge clk);

        // Zero code.
        bus_if.code = 16'h1011;
        push(2, 0);
        bus_if.req = 4'b0100;
        @(negedge clk);
        check("zero_ack", 64'(bus_if.ack), 64'(4'b0100));
        check("zero_led", 64'(bus_if.led), 64'd0);
        bus_if.req = 4'b0000;
        @(negedge clk);

        // Reset during second ON phase of requester 2.
        bus_if.code = 16'h0300;
        bus_if.req  = 4'b0100;
        rises = 0;
        n     = 0;
        prev  = 1'b0;
        while (rises < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus_if.led && !prev) rises++;
            prev = bus_if.led;
        end
        check("second_on", 64'(rises), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led", 64'(bus_if.led), 64'd0);
        check("arst_busy", 64'(bus_if.busy), 64'd0);
        check("arst_led1", 64'(bus_if.led1), 64'd0);
        check("arst_ack", 64'(bus_if.ack), 64'd0);
        bus_if.req  = 4'b0101;
        bus_if.code = 16'h0101;
        repeat (2) @(negedge clk);
        push(0, 1);
        push(2, 1);
        rst_n = 1'b1;
        wait_ack(0);
        wait_ack(2);

        repeat (4) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
